multibyte_add_seq: RTL
======================

// Module: multibyte_add_seq
// PURPOSE
//  Sequencer that performs wide (8*NBYTES-bit) additions by time-sharing one external
//  8-bit adder (a, d, carryin in; p, carryout out). Latches two wide operands on start,
//  feeds them byte by byte LSB-first, chains each byte's carry into the next byte, and
//  assembles the wide sum. Sits between the control logic and the adder datapath.
// PARAMETERS
//  NBYTES     4  operand width in bytes (>=1); wide width W = 8*NBYTES
//  ADDER_LAT  1  cycles from adder operands stable to p/carryout valid (0 = combinational adder)
// PORTS
//  clk        in   1    rising-edge clock
//  reset      in   1    synchronous, active-high reset
//  start      in   1    request a new operation; accepted only in IDLE
//  op_a       in   W    operand A, sampled on the accepting edge
//  op_b       in   W    operand B, sampled on the accepting edge
//  carryin    in   1    wide carry-in, sampled with operands
//  busy       out  1    high whenever state != IDLE
//  done       out  1    one-cycle pulse, result valid
//  sum        out  W    wide result register; holds until next completed op or reset
//  carryout   out  1    final carry of byte NBYTES-1; holds like sum
//  add_a      out  8    byte of A to adder
//  add_d      out  8    byte of B to adder
//  add_cin    out  1    chained carry to adder
//  add_p      in   8    adder sum byte
//  add_cout   in   1    adder carry out
// BEHAVIOUR
//  - States: IDLE -> DRIVE -> DONE -> IDLE. Byte index idx and hold counter hcnt.
//  - IDLE: start=1 latches op_a/op_b/carryin, idx=0, hcnt=0, carry reg=carryin -> DRIVE.
//  - DRIVE: add_a/add_d = byte idx of latched A/B, add_cin = carry reg; inputs held stable
//    for ADDER_LAT+1 cycles. On the edge ending the last hold cycle: sum byte idx <= add_p,
//    carry reg <= add_cout; if idx==NBYTES-1 -> DONE (carryout <= add_cout), else idx++, hcnt=0.
//  - DONE: done=1 for exactly one cycle, busy=1; -> IDLE. start here is ignored.
//  - Latency: cycle 0 = start accepted; done high in cycle NBYTES*(ADDER_LAT+1)+1
//    (NBYTES=4, ADDER_LAT=1: cycle 9). Next start accepted from the cycle after DONE.
//  - start while busy: ignored, no queueing; operand inputs may change freely while busy.
//  - In IDLE and DONE add_a=add_d=0, add_cin=0.
//  - Arithmetic: unsigned modulo 2^W; carryout is bit W of A+B+carryin.
//  - Reset (any cycle, incl. mid-operation): state=IDLE, busy=0, done=0, sum=0, carryout=0,
//    add_*=0, idx=hcnt=0; an interrupted op produces no done and no partial sum update.
//  - reset has priority over start in the same cycle.
// CONFIGURATION
//  MULTIBYTE_SUB_EN defined: extra input sub (1 bit, sampled with operands). sub=1 computes
//   A-B: add_d = ~byte of B, initial carry = 1 (carryin ignored), carryout = 1 means no
//   borrow (A>=B). sub=0 behaves as addition.
//  Not defined: no sub port; addition only, logic identical to the above with sub=0.
// TESTING (NBYTES=4, ADDER_LAT=1, registered 8-bit adder model)
//  1 reset high 2 cycles -> busy=0, done=0, sum=0, carryout=0, add_a=add_d=0, add_cin=0.
//  2 start, A=0x12345678, B=0x11111111, cin=0 -> done in cycle 9, sum=0x23456789, carryout=0.
//  3 A=0xFFFFFFFF, B=0x00000001, cin=0 -> sum=0x00000000, carryout=1 (carry ripples all bytes).
//  4 A=0x000000FF, B=0, cin=1 -> sum=0x00000100, carryout=0; start re-pulsed in cycles 3 and 9
//    ignored, start in cycle 10 accepted.
//  5 reset in cycle 4 of op (A=0x01010101,B=0x01010101) -> busy=0 next cycle, sum=0, no done;
//    following op A=1,B=2 -> sum=0x00000003.
//  6 MULTIBYTE_SUB_EN: sub=1, A=5, B=7 -> sum=0xFFFFFFFE, carryout=0; A=7,B=5 -> 2, carryout=1.

Source files
------------

// File: rtl/multibyte_add_seq.sv
// rtl/multibyte_add_seq.sv - wide adder sequencer time-sharing one external 8-bit adder
// Optional subtract mode (sub port) enabled by defining MULTIBYTE_SUB_EN.
module multibyte_add_seq #(
  parameter int NBYTES    = 4,
  parameter int ADDER_LAT = 1,
  localparam int W        = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         carryin,
`ifdef MULTIBYTE_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         carryout,
  output logic [7:0]   add_a,
  output logic [7:0]   add_d,
  output logic         add_cin,
  input  logic [7:0]   add_p,
  input  logic         add_cout
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int HW = (ADDER_LAT > 0) ? $clog2(ADDER_LAT + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NBYTES - 1);
  localparam logic [HW-1:0] LAST_HOLD = HW'(ADDER_LAT);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t state_q, state_d;

  logic [NBYTES-1:0][7:0] a_q, b_q, res_q, res_d, sum_q;
  logic [IW-1:0]          idx_q;
  logic [HW-1:0]          hcnt_q;
  logic                   carry_q, cout_q;
  logic                   hold_end, last_byte;
  logic                   init_carry, inv_b;

`ifdef MULTIBYTE_SUB_EN
  logic sub_q;
  // Subtraction is A + ~B + 1, so the caller's carryin is irrelevant.
  assign init_carry = sub ? 1'b1 : carryin;
  assign inv_b      = sub_q;
`else
  assign init_carry = carryin;
  assign inv_b      = 1'b0;
`endif

  assign sum      = sum_q;
  assign carryout = cout_q;

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    add_a     = 8'h00;
    add_d     = 8'h00;
    add_cin   = 1'b0;
    hold_end  = 1'b0;
    last_byte = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        add_a     = a_q[idx_q];
        add_d     = b_q[idx_q] ^ {8{inv_b}};
        add_cin   = carry_q;
        hold_end  = (hcnt_q == LAST_HOLD);
        last_byte = (idx_q == LAST_IDX);
        if (hold_end && last_byte) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Partial sums build up in res_q so the visible sum only changes on completion.
  always_comb begin
    res_d        = res_q;
    res_d[idx_q] = add_p;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      hcnt_q  <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef MULTIBYTE_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            idx_q   <= '0;
            hcnt_q  <= '0;
            carry_q <= init_carry;
`ifdef MULTIBYTE_SUB_EN
            sub_q   <= sub;
`endif
          end
        end
        S_DRIVE: begin
          if (hold_end) begin
            res_q   <= res_d;
            carry_q <= add_cout;
            hcnt_q  <= '0;
            if (last_byte) begin
              sum_q  <= res_d;
              cout_q <= add_cout;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
